// File: rtl/bitonic_sort_seq.sv
// bitonic_sort_seq: sequential 8-entry bitonic sorter.
// Eight numbers are loaded serially into a register file. One shared
// compare-exchange unit then runs the 24-step bitonic schedule, one step
// per cycle, and the sorted numbers are streamed out with index 0 first.
// Optional build macro: BITONIC_DESC_EN flips every compare direction, so
// the output comes out non-increasing instead of ascending.

module bitonic_sort_seq #(
    parameter int DW = 8,
    parameter int N  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] number_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] number_out,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SORT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [4:0] LAST_OP = 5'd23;

`ifdef BITONIC_DESC_EN
    localparam logic DIR_FLIP = 1'b1;
`else
    localparam logic DIR_FLIP = 1'b0;
`endif

    logic [1:0]    state;
    logic [2:0]    load_cnt;
    logic [2:0]    rd_ptr;
    logic [4:0]    op;
    logic [DW-1:0] mem [N];

    logic [3:0]    sub_k;
    logic [2:0]    sub_j;
    logic [1:0]    pair;
    logic [2:0]    idx_lo;
    logic [2:0]    idx_hi;
    logic          ascending;
    logic [DW-1:0] val_lo;
    logic [DW-1:0] val_hi;
    logic          swap_en;
    logic          load_en;

    // Decode the current op into its index pair and direction, and decide whether to swap
    always_comb begin
        sub_k = 4'd2;
        sub_j = 3'd1;
        case (op[4:2])
            3'd0:    begin sub_k = 4'd2; sub_j = 3'd1; end
            3'd1:    begin sub_k = 4'd4; sub_j = 3'd2; end
            3'd2:    begin sub_k = 4'd4; sub_j = 3'd1; end
            3'd3:    begin sub_k = 4'd8; sub_j = 3'd4; end
            3'd4:    begin sub_k = 4'd8; sub_j = 3'd2; end
            3'd5:    begin sub_k = 4'd8; sub_j = 3'd1; end
            default: begin sub_k = 4'd2; sub_j = 3'd1; end
        endcase

        // The p-th index with the j bit clear: insert a zero at bit position j
        pair = op[1:0];
        case (sub_j)
            3'd1:    idx_lo = {pair, 1'b0};
            3'd2:    idx_lo = {pair[1], 1'b0, pair[0]};
            default: idx_lo = {1'b0, pair};
        endcase
        idx_hi = idx_lo | sub_j;

        ascending = ((({1'b0, idx_lo}) & sub_k) == 4'd0) ^ DIR_FLIP;

        val_lo = mem[idx_lo];
        val_hi = mem[idx_hi];

        swap_en = (state == S_SORT) &&
                  (ascending ? (val_lo > val_hi) : (val_lo < val_hi));

        load_en = in_valid && in_ready;
    end

    // Register file: cleared on reset, written by input handshakes or by a compare-exchange swap
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < N; e++) begin
                mem[e] <= '0;
            end
        end else if (load_en) begin
            mem[load_cnt] <= number_in;
        end else if (swap_en) begin
            mem[idx_lo] <= val_hi;
            mem[idx_hi] <= val_lo;
        end
    end

    // Control FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            number_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_cnt   <= 3'd0;
            rd_ptr     <= 3'd0;
            op         <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (load_en) begin
                        load_cnt <= 3'd1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_en) begin
                        if (load_cnt == 3'd7) begin
                            in_ready <= 1'b0;
                            load_cnt <= 3'd0;
                            op       <= 5'd0;
                            state    <= S_SORT;
                        end else begin
                            load_cnt <= load_cnt + 3'd1;
                        end
                    end
                end
                S_SORT: begin
                    if (op == LAST_OP) begin
                        op     <= 5'd0;
                        rd_ptr <= 3'd0;
                        state  <= S_OUT;
                    end else begin
                        op <= op + 5'd1;
                    end
                end
                S_OUT: begin
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        number_out <= mem[rd_ptr];
                    end else if (out_ready) begin
                        if (rd_ptr == 3'd7) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            rd_ptr    <= 3'd0;
                            state     <= S_IDLE;
                        end else begin
                            rd_ptr     <= rd_ptr + 3'd1;
                            number_out <= mem[rd_ptr + 3'd1];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// tb_bitonic_sort_seq: directed vector bench for bitonic_sort_seq.
// Honours BITONIC_DESC_EN by reading the expected sorted table back to front.

module tb_bitonic_sort_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] number_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] number_out;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;
    int swap_count = 0;

    typedef struct packed {
        logic [63:0] din;
        logic [63:0] dexp;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    bitonic_sort_seq #(.DW(8), .N(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .number_in  (number_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .number_out (number_out),
        .busy       (busy),
        .done       (done)
    );

    // Count compare-exchange swaps actually performed
    always @(posedge clk) begin
        if (!reset && dut.swap_en) swap_count++;
    end

    // Element k of a packed vector, element 0 being the leftmost byte
    function automatic logic [7:0] elem(input logic [63:0] w, input int k);
        return w[63-8*k -: 8];
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] din, input bit gaps);
        int wait_cnt;
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            in_valid  = 1'b1;
            number_in = elem(din, k);
            wait_cnt  = 0;
            while (!in_ready && wait_cnt < 50) begin
                @(posedge clk); #1;
                wait_cnt++;
            end
            if (!in_ready) begin
                checkOutput("in_ready timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic collect(input int idx, input bit toggle);
        bit  hold_bad;
        bit  done_early;
        int  wait_cnt;
        logic [7:0] held;
        logic [7:0] exp;
        hold_bad   = 1'b0;
        done_early = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef BITONIC_DESC_EN
            exp = elem(vecs[idx].dexp, 7 - k);
`else
            exp = elem(vecs[idx].dexp, k);
`endif
            if (toggle) begin
                for (int s = 0; s < 4 && $urandom_range(0, 1) == 0; s++) begin
                    out_ready = 1'b0;
                    held = number_out;
                    @(posedge clk); #1;
                    if (number_out != held || !out_valid || in_ready) hold_bad = 1'b1;
                end
            end
            wait_cnt = 0;
            while (!out_valid && wait_cnt < 50) begin
                @(posedge clk); #1;
                wait_cnt++;
            end
            checkOutput($sformatf("v%0d out_valid[%0d]", idx, k), out_valid, 1);
            checkOutput($sformatf("v%0d number_out[%0d]", idx, k), number_out, exp);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = toggle ? 1'b0 : 1'b1;
            if (k < 7 && done) done_early = 1'b1;
        end
        checkOutput($sformatf("v%0d done pulse", idx), done, 1);
        checkOutput($sformatf("v%0d out_valid after last", idx), out_valid, 0);
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d done cleared", idx), done, 0);
        checkOutput($sformatf("v%0d in_ready back", idx), in_ready, 1);
        checkOutput($sformatf("v%0d busy idle", idx), busy, 0);
        checkOutput($sformatf("v%0d early done", idx), done_early, 0);
        if (toggle) checkOutput($sformatf("v%0d hold stable", idx), hold_bad, 0);
        out_ready = 1'b0;
    endtask

    task automatic run_batch(input int idx, input bit gaps, input bit toggle);
        int lat;
        bit bad_ready;
        bit bad_busy;
        out_ready = toggle ? 1'b0 : 1'b1;
        applyStimulus(vecs[idx].din, gaps);
        // junk input while sorting must be ignored
        in_valid  = 1'b1;
        number_in = 8'hEE;
        lat       = 0;
        bad_ready = 1'b0;
        bad_busy  = 1'b0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) bad_ready = 1'b1;
            if (!busy) bad_busy = 1'b1;
        end
        in_valid = 1'b0;
        checkOutput($sformatf("v%0d latency", idx), lat, 25);
        checkOutput($sformatf("v%0d in_ready low in sort", idx), bad_ready, 0);
        checkOutput($sformatf("v%0d busy in sort", idx), bad_busy, 0);
        collect(idx, toggle);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{din: 64'h0807060504030201, dexp: 64'h0102030405060708};
        vecs[1] = '{din: 64'h10FF0080107F01FE, dexp: 64'h000110107F80FEFF};
        vecs[2] = '{din: 64'h5555555555555555, dexp: 64'h5555555555555555};
        vecs[3] = '{din: 64'h0301020007050604, dexp: 64'h0001020304050607};
        vecs[4] = '{din: 64'h0102030405060708, dexp: 64'h0102030405060708};
        vecs[5] = '{din: 64'hA305C83E910500FF, dexp: 64'h0005053E91A3C8FF};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        number_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset number_out", number_out, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle in_ready", in_ready, 1);
        checkOutput("idle busy", busy, 0);

        for (int v = 0; v < 6; v++) begin
            if (v == 2) swap_count = 0;
            run_batch(v, (v == 5), (v >= 4));
            if (v == 2) checkOutput("all-equal swaps", swap_count, 0);
        end

        // reset while op 10 is in flight
        applyStimulus(vecs[0].din, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("mid-sort busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort out_valid", out_valid, 0);
        checkOutput("abort in_ready", in_ready, 0);
        @(posedge clk); #1;
        checkOutput("abort then idle in_ready", in_ready, 1);
        run_batch(3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
